// File: rtl/cache_pkg.sv
// Shared cache replacement definitions: LFSR constants and generic
// one-hot/binary helpers sized for the widest supported cache (128 ways).
package cache_pkg;

    // Replacement LFSR geometry
    localparam int unsigned LFSR_W = 7;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;
    // Feedback taps at bit positions 6, 5, 3 and 0
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'b110_1001;

    // Widest supported way count; helpers work at this width and callers
    // cast the result down to their own NUMWAYS / LOGNUMWAYS.
    localparam int unsigned MAX_WAYS = 128;
    localparam int unsigned MAX_LOG  = 7;

    // One-hot to binary. A multi-hot input returns the OR of all set indices.
    function automatic logic [MAX_LOG-1:0] oneHotToBin(input logic [MAX_WAYS-1:0] oneHot);
        logic [MAX_LOG-1:0] bin;
        bin = '0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (oneHot[i]) begin
                bin = bin | MAX_LOG'(i);
            end
        end
        return bin;
    endfunction

    // Binary to one-hot decode.
    function automatic logic [MAX_WAYS-1:0] binToOneHot(input logic [MAX_LOG-1:0] bin);
        logic [MAX_WAYS-1:0] oneHot;
        oneHot      = '0;
        oneHot[bin] = 1'b1;
        return oneHot;
    endfunction

    // Keep only the lowest-indexed set bit; zero in gives zero out.
    function automatic logic [MAX_WAYS-1:0] lowestSet(input logic [MAX_WAYS-1:0] vec);
        logic [MAX_WAYS-1:0] oneHot;
        logic                found;
        oneHot = '0;
        found  = 1'b0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (vec[i] && !found) begin
                oneHot[i] = 1'b1;
                found     = 1'b1;
            end
        end
        return oneHot;
    endfunction

endpackage

// File: rtl/lfsr7_en.sv
// Enabled 7-bit Fibonacci LFSR. Asynchronous active-low reset loads the seed;
// the feedback includes bit 0, so the map is invertible and never reaches 0.
module lfsr7_en
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] stateReg;
    logic              feedback;

    // XOR of the tapped bits becomes the new MSB
    always_comb begin
        feedback = ^(stateReg & LFSR_TAPS);
    end

    // Shift right by one on each enabled cycle, seed on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg <= LFSR_SEED;
        end else if (en) begin
            stateReg <= {feedback, stateReg[LFSR_W-1:1]};
        end
    end

    assign state = stateReg;

endmodule

// File: rtl/lfsr_victim_sel.sv
// Random-replacement victim selector. Prefers the lowest invalid way; when
// the set is full the victim comes from the low bits of the LFSR. Also
// binary-encodes the hit vector for the datapath.
module lfsr_victim_sel
    import cache_pkg::*;
#(
    parameter int unsigned NUMWAYS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       FlushStage,
    input  logic                       LRUWriteEn,
    input  logic [NUMWAYS-1:0]         ValidWay,
    input  logic [NUMWAYS-1:0]         HitWay,
    output logic [$clog2(NUMWAYS)-1:0] HitWayEnc,
    output logic [NUMWAYS-1:0]         VictimWay,
    output logic [LFSR_W-1:0]          LfsrState
);

    localparam int unsigned LOGNUMWAYS = $clog2(NUMWAYS);

    // Reject unsupported way counts at elaboration
    if (NUMWAYS < 2 || NUMWAYS > MAX_WAYS || (NUMWAYS & (NUMWAYS - 1)) != 0) begin : gBadNumWays
        $error("lfsr_victim_sel: NUMWAYS must be a power of two in 2..128");
    end

    logic                  lfsrEn;
    logic [LFSR_W-1:0]     lfsrState;
    logic                  allValid;
    logic [NUMWAYS-1:0]    invalidWay;
    logic [MAX_WAYS-1:0]   firstZero;
    logic [LOGNUMWAYS-1:0] firstZeroWay;
    logic [LOGNUMWAYS-1:0] victimEnc;

    // A flush squashes the replacement update, so it also blocks the advance
    always_comb begin
        lfsrEn = LRUWriteEn & ~FlushStage;
    end

    lfsr7_en u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (lfsrEn),
        .state (lfsrState)
    );

    // Victim choice: lowest invalid way wins, otherwise the LFSR low bits
    always_comb begin
        allValid     = &ValidWay;
        // Invert at native width before widening so padding stays zero
        invalidWay   = ~ValidWay;
        firstZero    = lowestSet(MAX_WAYS'(invalidWay));
        firstZeroWay = LOGNUMWAYS'(oneHotToBin(firstZero));
        victimEnc    = allValid ? lfsrState[LOGNUMWAYS-1:0] : firstZeroWay;
        VictimWay    = NUMWAYS'(binToOneHot(MAX_LOG'(victimEnc)));
    end

    // Hit vector encode; multi-hot ORs the indices together
    always_comb begin
        HitWayEnc = LOGNUMWAYS'(oneHotToBin(MAX_WAYS'(HitWay)));
    end

    assign LfsrState = lfsrState;

endmodule

// File: tb/tb_lfsr_victim_sel.sv
// Self-checking bench for lfsr_victim_sel: directed vector table, an
// asynchronous reset corner, and a randomized run against a reference model
// on 4-, 128- and 2-way instances sharing one clock and control set.
module tb_lfsr_victim_sel;

    logic         clk;
    logic         reset;
    logic         FlushStage;
    logic         LRUWriteEn;

    logic [3:0]   valid4;
    logic [3:0]   hit4;
    logic [1:0]   hitEnc4;
    logic [3:0]   victim4;
    logic [6:0]   state4;

    logic [127:0] valid128;
    logic [127:0] hit128;
    logic [6:0]   hitEnc128;
    logic [127:0] victim128;
    logic [6:0]   state128;

    logic [1:0]   valid2;
    logic [1:0]   hit2;
    logic [0:0]   hitEnc2;
    logic [1:0]   victim2;
    logic [6:0]   state2;

    int nChecks = 0;
    int nFail   = 0;
    int modelR;

    lfsr_victim_sel #(.NUMWAYS(4)) u_dut4 (
        .clk(clk), .reset(reset), .FlushStage(FlushStage), .LRUWriteEn(LRUWriteEn),
        .ValidWay(valid4), .HitWay(hit4), .HitWayEnc(hitEnc4), .VictimWay(victim4),
        .LfsrState(state4)
    );

    lfsr_victim_sel #(.NUMWAYS(128)) u_dut128 (
        .clk(clk), .reset(reset), .FlushStage(FlushStage), .LRUWriteEn(LRUWriteEn),
        .ValidWay(valid128), .HitWay(hit128), .HitWayEnc(hitEnc128), .VictimWay(victim128),
        .LfsrState(state128)
    );

    lfsr_victim_sel #(.NUMWAYS(2)) u_dut2 (
        .clk(clk), .reset(reset), .FlushStage(FlushStage), .LRUWriteEn(LRUWriteEn),
        .ValidWay(valid2), .HitWay(hit2), .HitWayEnc(hitEnc2), .VictimWay(victim2),
        .LfsrState(state2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference LFSR step written from the recurrence with integer arithmetic
    function automatic int refStep(input int r);
        int fb;
        fb = ((r >> 6) ^ (r >> 5) ^ (r >> 3) ^ r) & 1;
        return (fb << 6) | (r >> 1);
    endfunction

    // Expected one-hot victim: first invalid way, else LFSR value modulo ways
    function automatic logic [127:0] refVictim(input logic [127:0] valid, input int ways,
                                               input int r);
        logic [127:0] one;
        one = 128'd1;
        for (int i = 0; i < ways; i++) begin
            if (!valid[i]) return one << i;
        end
        return one << (r % ways);
    endfunction

    function automatic logic [127:0] refHitEnc(input logic [127:0] hit, input int ways);
        int acc;
        acc = 0;
        for (int i = 0; i < ways; i++) begin
            if (hit[i]) acc = acc | i;
        end
        return 128'(acc);
    endfunction

    typedef struct {
        logic       lru;
        logic       flush;
        logic [3:0] valid;
        logic [3:0] hit;
        logic [6:0] expState;
        logic [3:0] expVictim;
        logic [1:0] expEnc;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int enabledCount;
        int cyc;
        int idx;
        logic [127:0] one;

        // lru, flush, valid, hit, state after edge, victim, hit encode
        vecs[0]  = '{1'b1, 1'b0, 4'b1111, 4'b0001, 7'h40, 4'b0001, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 4'b1111, 4'b0010, 7'h60, 4'b0001, 2'd1};
        vecs[2]  = '{1'b1, 1'b0, 4'b1111, 4'b0100, 7'h30, 4'b0001, 2'd2};
        vecs[3]  = '{1'b1, 1'b0, 4'b1111, 4'b1000, 7'h58, 4'b0001, 2'd3};
        vecs[4]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 7'h58, 4'b0001, 2'd0};
        vecs[5]  = '{1'b0, 1'b0, 4'b1111, 4'b0000, 7'h58, 4'b0001, 2'd0};
        vecs[6]  = '{1'b0, 1'b0, 4'b1011, 4'b0000, 7'h58, 4'b0100, 2'd0};
        vecs[7]  = '{1'b0, 1'b0, 4'b0110, 4'b0000, 7'h58, 4'b0001, 2'd0};
        vecs[8]  = '{1'b1, 1'b0, 4'b1011, 4'b0000, 7'h2C, 4'b0100, 2'd0};
        vecs[9]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 7'h16, 4'b0100, 2'd0};
        vecs[10] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 7'h0B, 4'b1000, 2'd0};
        vecs[11] = '{1'b1, 1'b0, 4'b0110, 4'b0000, 7'h05, 4'b0001, 2'd0};
        vecs[12] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 7'h05, 4'b0010, 2'd0};

        reset      = 1'b0;
        FlushStage = 1'b0;
        LRUWriteEn = 1'b0;
        valid4     = 4'b1111;
        hit4       = 4'b0000;
        valid128   = '1;
        hit128     = '0;
        valid2     = 2'b11;
        hit2       = 2'b00;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 128'(state4), 128'h01);
        check("reset_victim", 128'(victim4), 128'(4'b0010));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_release_state", 128'(state4), 128'h01);
        check("post_release_victim", 128'(victim4), 128'(4'b0010));

        // Directed vector table, one clock per entry
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            LRUWriteEn = vecs[i].lru;
            FlushStage = vecs[i].flush;
            valid4     = vecs[i].valid;
            hit4       = vecs[i].hit;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_state", i), 128'(state4), 128'(vecs[i].expState));
            check($sformatf("vec%0d_victim", i), 128'(victim4), 128'(vecs[i].expVictim));
            check($sformatf("vec%0d_hitenc", i), 128'(hitEnc4), 128'(vecs[i].expEnc));
        end

        // Reset asserted between edges must act at once
        @(negedge clk);
        LRUWriteEn = 1'b0;
        FlushStage = 1'b0;
        valid4     = 4'b1111;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_state", 128'(state4), 128'h01);
        check("async_reset_victim", 128'(victim4), 128'(4'b0010));
        check("async_reset_state128", 128'(state128), 128'h01);
        @(negedge clk);
        reset  = 1'b1;
        modelR = 1;

        // Randomized run until 300 enabled cycles have been checked
        enabledCount = 0;
        cyc          = 0;
        one          = 128'd1;
        while (enabledCount < 300 && cyc < 3000) begin
            cyc++;
            @(negedge clk);
            LRUWriteEn = ($urandom_range(0, 3) != 0);
            FlushStage = ($urandom_range(0, 4) == 0);
            valid4     = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
            valid2     = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'($urandom);
            valid128   = '1;
            if ($urandom_range(0, 3) == 0) valid128[$urandom_range(0, 127)] = 1'b0;
            hit4       = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'(one << $urandom_range(0, 3));
            hit128     = one << $urandom_range(0, 127);
            hit2       = 2'($urandom);
            @(posedge clk);
            if (LRUWriteEn && !FlushStage) begin
                modelR = refStep(modelR);
                enabledCount++;
            end
            #1;
            check("rand_state", 128'(state4), 128'(modelR));
            if (state4 == 7'd0) begin
                nFail++;
                $display("FAIL rand_state_zero: got %h expected nonzero", state4);
            end
            check("rand_victim4", 128'(victim4), refVictim(128'(valid4), 4, modelR));
            check("rand_hitenc4", 128'(hitEnc4), refHitEnc(128'(hit4), 4));
            check("rand_state128", 128'(state128), 128'(modelR));
            check("rand_victim128", victim128, refVictim(valid128, 128, modelR));
            check("rand_hitenc128", 128'(hitEnc128), refHitEnc(hit128, 128));
            check("rand_victim2", 128'(victim2), refVictim(128'(valid2), 2, modelR));
            check("rand_hitenc2", 128'(hitEnc2), refHitEnc(128'(hit2), 2));
        end
        check("rand_enabled_cycles", 128'(enabledCount), 128'd300);

        // 128-way corners: top hit bit, and full set uses all seven LFSR bits
        @(negedge clk);
        LRUWriteEn = 1'b0;
        FlushStage = 1'b0;
        hit128     = one << 127;
        valid128   = '1;
        #1;
        check("hitenc128_top", 128'(hitEnc128), 128'd127);
        idx = modelR;
        check("victim128_full", victim128, one << idx);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/lfsr_victim_sel.md
Name: lfsr_victim_sel

Overview:
- Random-replacement victim-way selector for a set-associative cache, used in both the I-cache and the D-cache.
- Produces a one-hot victim way. The victim is the lowest-indexed invalid way if any way in the set is invalid; otherwise it is taken from the low bits of a 7-bit Fibonacci LFSR.
- Also binary-encodes the one-hot hit vector so the cache datapath can use it.
- Purely combinational outputs, except the LFSR state register.

Parameters:
- NUMWAYS, 4, number of cache ways. Must be a power of two, 2..128. Values outside this range are a compile-time error.
- LOGNUMWAYS, $clog2(NUMWAYS), derived local parameter, not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (asserted when 0)
- FlushStage  input  1  pipeline flush; blocks LFSR advance
- LRUWriteEn  input  1  replacement-state update strobe; advances the LFSR
- ValidWay  input  NUMWAYS  valid bits of the addressed set, bit i = way i
- HitWay  input  NUMWAYS  one-hot (or zero) tag-match vector
- HitWayEnc  output  LOGNUMWAYS  binary index of the set bit in HitWay
- VictimWay  output  NUMWAYS  one-hot victim way
- LfsrState  output  7  current LFSR contents, for debug and verification

Behaviour:
- LFSR register r[6:0]:
  - While reset = 0 (asynchronous), r = 7'b0000001.
  - After reset is released, on each rising clk with en = LRUWriteEn & ~FlushStage: r <= {next, r[6:1]}, where next = r[6] ^ r[5] ^ r[3] ^ r[0].
  - en = 0: r holds.
  - FlushStage = 1 overrides LRUWriteEn = 1.
  - Reset asserted mid-operation takes effect immediately, without waiting for a clock edge.
  - r never becomes 0 from a nonzero state, because the feedback includes r[0] and the map is invertible.
- Sequence from reset, one advance per enabled cycle: 0x01, 0x40, 0x60, 0x30, 0x58, ...
- Victim encoding:
  - AllValid = &ValidWay.
  - FirstZero = one-hot of the lowest-index 0 bit in ValidWay.
  - FirstZeroWay = binary index of FirstZero.
  - VictimEnc = AllValid ? r[LOGNUMWAYS-1:0] : FirstZeroWay.
  - VictimWay = one-hot decode of VictimEnc: bit VictimEnc = 1, all other bits 0.
  - VictimWay is combinational from ValidWay and r. It changes the cycle after r advances.
  - VictimWay depends on ValidWay and r only; HitWay and LRUWriteEn do not affect it.
- HitWayEnc: combinational binary encode of HitWay.
  - HitWay = 0 yields 0.
  - Multi-hot HitWay yields the OR of the indices of all set bits. This is defined, but it is illegal input.
- Reset values:
  - LfsrState = 0x01.
  - With all ways valid, VictimWay = 1 << (1 & (NUMWAYS-1)), i.e. way 1.
  - HitWayEnc follows its input.
- NUMWAYS = 128: all 7 LFSR bits are used.
- NUMWAYS = 2: only r[0] is used.
- No handshakes. Single clock domain.

Decomposition:
- Shared package cache_pkg holds:
  - LFSR_W = 7
  - LFSR_SEED = 7'h01
  - tap positions {6, 5, 3, 0}
- Generic helpers from the library are reused: onehot-to-binary encoder, binary-to-onehot decoder, lowest-set priority one-hot.
- One natural sub-module: lfsr7_en. It is an enabled 7-bit shift register with asynchronous active-low load of LFSR_SEED.

Test Plan:
- Reset = 0 for 2 cycles, then released; NUMWAYS=4, ValidWay=4'b1111 -> LfsrState=0x01, VictimWay=4'b0010. Assert reset = 0 between clock edges -> LfsrState returns to 0x01 immediately.
- LRUWriteEn=1, FlushStage=0 for 4 cycles, ValidWay=4'b1111 -> LfsrState = 0x40, 0x60, 0x30, 0x58. VictimWay = 0001 in each of those cycles.
- Enable gating:
  - LRUWriteEn=1 with FlushStage=1 -> state held.
  - LRUWriteEn=0 -> state held.
  - Run 300 enabled cycles against a reference model -> every step matches, and LfsrState is never 0.
- Invalid-way priority: ValidWay=4'b1011 -> VictimWay=4'b0100. ValidWay=4'b0110 -> VictimWay=4'b0001. Both results are independent of LfsrState.
- HitWayEnc:
  - HitWay = 0001, 0010, 0100, 1000 -> 0, 1, 2, 3.
  - HitWay=0000 -> 0.
  - NUMWAYS=128 build: HitWay bit 127 -> 127. All ways valid -> VictimWay bit LfsrState set.
